hyperram_txn_sched: RTL and testbench
=====================================

# hyperram_txn_sched

Transaction scheduler for the HyperRAM controller. It arbitrates round-robin between NREQ requesters and builds the 48-bit HyperBus command/address word (casig). It starts exactly one transaction engine at a time (register read, memory write, memory read, register write) and drives the engine select used by the PHY-signal mux. It forwards read data and completion back to the granted requester and enforces a minimum CS# recovery gap between transactions.

## Interface
Parameters:
- NREQ, 2, number of requesters (1..4); IDW = max(1, clog2(NREQ))
- TRECOV, 4, idle cycles after engine end before next dispatch (≥1)
- TIMEOUT, 64, max cycles in WAIT before abort

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  request pending per requester; held until accepted
- req_op  in  2*NREQ  per requester: 00 RDREG, 01 WRMEM, 10 RDMEM, 11 WRREG
- req_addr  in  32*NREQ  per requester word address
- req_ready  out  NREQ  one-cycle accept pulse, one-hot
- casig  out  48  CA word to all engines
- eng_start  out  4  start pulse, bit index = op
- eng_end  in  4  engine stm_end, bit index = op
- eng_sel  out  2  op of active engine, for the csn/oe/oe_clk/datain mux
- eng_rd_valid  in  2  [0] rdreg valid, [1] rdmem valid
- eng_rd_data  in  32  [15:0] rdreg data, [31:16] rdmem data
- rsp_dvalid  out  1  read data beat
- rsp_data  out  16  read data
- rsp_done  out  1  one-cycle completion pulse
- rsp_err  out  1  qualifies rsp_done: timeout or rejected op
- rsp_id  out  IDW  requester owning the current rsp_*
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, LOAD, START, WAIT, RECOV.
- IDLE → LOAD when any req_valid. Winner is the first valid index after rr_ptr, cyclically. Register gid, op, and addr. rr_ptr ← gid.
- LOAD: req_ready[gid]=1. casig registered:
  - [47] = 1 for RDREG/RDMEM
  - [46] = 1 for RDREG/WRREG
  - [45] = 1 (linear burst)
  - [44:16] = addr[31:3]
  - [15:3] = 0
  - [2:0] = addr[2:0]
- eng_sel ← op and rsp_id ← gid in LOAD. Both are held until IDLE is re-entered.
- START: eng_start[op]=1 for exactly one cycle; casig is stable. → WAIT, timeout counter cleared.
- WAIT:
  - For RDREG, rsp_dvalid = eng_rd_valid[0] and rsp_data = eng_rd_data[15:0], both registered.
  - For RDMEM, the same using eng_rd_valid[1] and eng_rd_data[31:16]. A RDMEM burst yields 16 beats.
  - For write ops, rsp_dvalid stays 0.
  - eng_end[op] → rsp_done=1 next cycle with rsp_err=0, → RECOV.
  - If the counter reaches TIMEOUT without end → rsp_done=1 with rsp_err=1, → RECOV.
- RECOV: count TRECOV cycles, then → IDLE. Requests are not sampled in RECOV.
- eng_end bits other than eng_end[op], and eng_rd_valid outside WAIT, are ignored.
- Timeout counter width is clog2(TIMEOUT+1) and saturates.

## Timing
- Reset values: every output 0, including casig, eng_sel, rsp_id, and all pulses. rr_ptr = NREQ-1, so requester 0 wins first. State is IDLE.
- Request sampled in IDLE at cycle 0 → req_ready at cycle 1 → eng_start at cycle 2.
- eng_end at cycle N → rsp_done at N+1 → earliest next req_ready at N+1+TRECOV+1.
- Read beat latency is 1 cycle (eng_rd_valid at c → rsp_dvalid at c+1). The final RDMEM beat precedes or coincides with rsp_done.
- Simultaneous requests: the round-robin order is strict. A requester that deasserts before LOAD is still granted from its registered values; requesters must hold req_valid until req_ready.
- Back-to-back from the same requester with others idle: allowed, separated by RECOV.
- Reset mid-transaction: state returns to IDLE within the same edge and no rsp_done is emitted. Engines share rst.

## Configuration
- HRAM_SCHED_WRREG_EN defined: op 11 is dispatched to eng_start[3] like the other ops.
- Not defined: op 11 is still granted (req_ready in LOAD). The FSM then skips START/WAIT and goes to RECOV with rsp_done=1, rsp_err=1 at cycle 2. eng_start[3] is never asserted.

## Test plan
- Reset, then idle 10 cycles → all outputs 0, busy=0.
- Req0 RDREG addr 0x0000_0001 → casig 0xE000_0000_0001. eng_start=0001 at cycle 2. Model end after 16 cycles with data 0x8F1F → one rsp_dvalid with 0x8F1F, rsp_done with rsp_err=0, rsp_id=0.
- Req1 RDMEM addr 0x0000_0010 → casig 0xA000_0002_0000. Model 16 beats 0x0000..0x000F → 16 rsp_dvalid in order, then rsp_done. Next grant no earlier than 5 cycles after rsp_done.
- Req0 and req1 both WRMEM continuously → grants alternate 0,1,0,1. casig[47]=0, eng_sel=01, each rsp_done error-free.
- RDMEM with eng_end never asserted → rsp_done with rsp_err=1 exactly 65 cycles after eng_start, then RECOV.
- WRREG with macro undefined → req_ready then rsp_done/rsp_err=1, no eng_start. Macro defined → eng_start=1000 at cycle 2. Assert rst in WAIT → outputs 0 next cycle, no rsp_done.

Source files
------------

// File: rtl/hyperram_txn_sched.sv
// HyperRAM transaction scheduler: round-robin grant, CA word build, one engine at a time.
// Define HRAM_SCHED_WRREG_EN to dispatch register writes; otherwise they complete with rsp_err.
module hyperram_txn_sched #(
    parameter int NREQ    = 2,
    parameter int TRECOV  = 4,
    parameter int TIMEOUT = 64,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [2*NREQ-1:0]   req_op,
    input  logic [32*NREQ-1:0]  req_addr,
    output logic [NREQ-1:0]     req_ready,
    output logic [47:0]         casig,
    output logic [3:0]          eng_start,
    input  logic [3:0]          eng_end,
    output logic [1:0]          eng_sel,
    input  logic [1:0]          eng_rd_valid,
    input  logic [31:0]         eng_rd_data,
    output logic                rsp_dvalid,
    output logic [15:0]         rsp_data,
    output logic                rsp_done,
    output logic                rsp_err,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(TRECOV + 1);

    localparam logic [1:0] OP_RDREG = 2'b00;
    localparam logic [1:0] OP_RDMEM = 2'b10;
    localparam logic [1:0] OP_WRREG = 2'b11;

`ifdef HRAM_SCHED_WRREG_EN
    localparam bit WRREG_EN = 1'b1;
`else
    localparam bit WRREG_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RECOV} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gid;
    logic [1:0]      op;
    logic [31:0]     addr;
    logic [TW-1:0]   tcnt;
    logic [RW-1:0]   rcnt;
    logic [IDW-1:0]  win_id;

    // First valid requester strictly after the last grant, wrapping.
    always_comb begin
        win_id = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NREQ])
                win_id = IDW'((int'(rr_ptr) + k) % NREQ);
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= IDW'(NREQ - 1);
            gid        <= '0;
            op         <= '0;
            addr       <= '0;
            tcnt       <= '0;
            rcnt       <= '0;
            req_ready  <= '0;
            casig      <= '0;
            eng_start  <= '0;
            eng_sel    <= '0;
            rsp_id     <= '0;
            rsp_dvalid <= 1'b0;
            rsp_data   <= '0;
            rsp_done   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            req_ready  <= '0;
            eng_start  <= '0;
            rsp_dvalid <= 1'b0;
            rsp_done   <= 1'b0;
            rsp_err    <= 1'b0;
            case (state)
                IDLE: if (|req_valid) begin
                    state     <= LOAD;
                    gid       <= win_id;
                    rr_ptr    <= win_id;
                    op        <= req_op[2*int'(win_id) +: 2];
                    addr      <= req_addr[32*int'(win_id) +: 32];
                    req_ready <= NREQ'(1) << win_id;
                end
                LOAD: begin
                    casig   <= {(op == OP_RDREG || op == OP_RDMEM),
                                (op == OP_RDREG || op == OP_WRREG),
                                1'b1, addr[31:3], 13'd0, addr[2:0]};
                    eng_sel <= op;
                    rsp_id  <= gid;
                    // Without a register-write engine the op is granted and failed immediately.
                    if (op == OP_WRREG && !WRREG_EN) begin
                        state    <= RECOV;
                        rcnt     <= '0;
                        rsp_done <= 1'b1;
                        rsp_err  <= 1'b1;
                    end else begin
                        state     <= START;
                        eng_start <= 4'b0001 << op;
                    end
                end
                START: begin
                    state <= WAIT;
                    tcnt  <= '0;
                end
                WAIT: begin
                    if (op == OP_RDREG) begin
                        rsp_dvalid <= eng_rd_valid[0];
                        rsp_data   <= eng_rd_data[15:0];
                    end else if (op == OP_RDMEM) begin
                        rsp_dvalid <= eng_rd_valid[1];
                        rsp_data   <= eng_rd_data[31:16];
                    end
                    if (eng_end[op]) begin
                        state    <= RECOV;
                        rcnt     <= '0;
                        rsp_done <= 1'b1;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        // tcnt counts completed WAIT cycles; this is the TIMEOUT-th.
                        state    <= RECOV;
                        rcnt     <= '0;
                        rsp_done <= 1'b1;
                        rsp_err  <= 1'b1;
                    end else if (tcnt != TW'(TIMEOUT)) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RECOV: begin
                    if (rcnt == RW'(TRECOV - 1))
                        state <= IDLE;
                    else
                        rcnt <= rcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hyperram_txn_sched.sv
// Self-checking bench for hyperram_txn_sched: transaction table with an engine model
// and a read-data scoreboard, plus sequences for alternation and mid-transaction reset.
module tb_hyperram_txn_sched;
    localparam int NREQ = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [2*NREQ-1:0]   req_op = '0;
    logic [32*NREQ-1:0]  req_addr = '0;
    logic [NREQ-1:0]     req_ready;
    logic [47:0]         casig;
    logic [3:0]          eng_start;
    logic [3:0]          eng_end = '0;
    logic [1:0]          eng_sel;
    logic [1:0]          eng_rd_valid = '0;
    logic [31:0]         eng_rd_data = '0;
    logic                rsp_dvalid;
    logic [15:0]         rsp_data;
    logic                rsp_done;
    logic                rsp_err;
    logic [0:0]          rsp_id;
    logic                busy;

    hyperram_txn_sched #(.NREQ(NREQ), .TRECOV(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_ready(req_ready),
        .casig(casig), .eng_start(eng_start), .eng_end(eng_end), .eng_sel(eng_sel),
        .eng_rd_valid(eng_rd_valid), .eng_rd_data(eng_rd_data),
        .rsp_dvalid(rsp_dvalid), .rsp_data(rsp_data), .rsp_done(rsp_done),
        .rsp_err(rsp_err), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [47:0] casig;
        int          lat;    // cycles after eng_start when the engine ends
        int          nb;     // read beats, the last one coinciding with end
        logic [15:0] dbase;
        bit          hang;   // engine never ends
        int          glat;   // 1: wait for idle first; 5: issue straight after rsp_done
    } txn_t;

    int          tests = 0;
    int          fails = 0;
    int          last_gid = 0;
    logic [15:0] sb[$];
    txn_t        tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", busy, 0);
    endtask

    task automatic run_txn(input txn_t t);
        int n;
        int dc;
        int first;
        logic [15:0] v;
        if (t.glat == 1) wait_idle();
        req_valid[t.id] = 1'b1;
        req_op[2*t.id +: 2] = t.op;
        req_addr[32*t.id +: 32] = t.addr;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (req_ready == '0 && n < 100);
        chk("grant_lat", n, t.glat);
        chk("req_ready", req_ready, 1 << t.id);
        last_gid = t.id;
        req_valid[t.id] = 1'b0;
        @(posedge clk); #1;
`ifndef HRAM_SCHED_WRREG_EN
        if (t.op == 2'b11) begin
            chk("wrreg_start", eng_start, 0);
            chk("wrreg_done_err", {rsp_done, rsp_err}, 2'b11);
            chk("wrreg_id", rsp_id, t.id);
            return;
        end
`endif
        chk("eng_start", eng_start, 1 << t.op);
        chk("casig", casig, t.casig);
        chk("eng_sel", eng_sel, t.op);
        chk("rsp_id", rsp_id, t.id);
        first = t.lat - t.nb + 1;
        dc = 0;
        for (int c = 0; c < 200 && dc == 0; c++) begin
            eng_end = '0;
            eng_rd_valid = '0;
            eng_rd_data = $urandom;
            if (c == 0) eng_rd_valid = 2'b11;                 // START: must be ignored
            if (c == 1) eng_end = 4'b1111 ^ (4'b0001 << t.op); // foreign ends ignored
            if (!t.hang && t.nb > 0 && c >= first && c <= t.lat) begin
                v = t.dbase + 16'(c - first);
                eng_rd_valid = 2'b11;                          // other lane carries junk
                if (t.op == 2'b00) eng_rd_data[15:0] = v;
                else eng_rd_data[31:16] = v;
                sb.push_back(v);
            end
            if ((t.op == 2'b01 || t.op == 2'b11) && c == 2) eng_rd_valid = 2'b11;
            if (!t.hang && c == t.lat) eng_end[t.op] = 1'b1;
            @(posedge clk); #1;
            if (c == 0) chk("start_pulse", eng_start, 0);
            if (rsp_dvalid) begin
                chk("beat_expected", sb.size() != 0, 1);
                if (sb.size() != 0) chk("rsp_data", rsp_data, sb.pop_front());
            end
            if (rsp_done) dc = c + 1;
        end
        eng_end = '0;
        eng_rd_valid = '0;
        chk("done_cycle", dc, t.hang ? 65 : t.lat + 1);
        chk("rsp_err", rsp_err, t.hang);
        chk("done_id", rsp_id, t.id);
        chk("beats_left", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int n;
        int exp_id;
        tbl[0] = '{0, 2'b00, 32'h0000_0001, 48'hE000_0000_0001, 16, 1,  16'h8F1F, 0, 1};
        tbl[1] = '{1, 2'b10, 32'h0000_0010, 48'hA000_0002_0000, 17, 16, 16'h0000, 0, 1};
        tbl[2] = '{0, 2'b01, 32'hDEAD_BEEF, 48'h3BD5_B7DD_0007, 5,  0,  16'h0000, 0, 5};
        tbl[3] = '{1, 2'b00, 32'h1234_5678, 48'hE246_8ACF_0000, 3,  1,  16'hA55A, 0, 5};
        tbl[4] = '{1, 2'b00, 32'h0000_0007, 48'hE000_0000_0007, 1,  1,  16'h0F0F, 0, 5};
        tbl[5] = '{0, 2'b11, 32'h0000_000F, 48'h6000_0001_0007, 4,  0,  16'h0000, 0, 1};
        tbl[6] = '{1, 2'b10, 32'h0000_0008, 48'hA000_0001_0000, 0,  0,  16'h0000, 1, 1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_outs", {req_ready, eng_start, eng_sel, rsp_dvalid, rsp_done, rsp_err, rsp_id}, 0);
        chk("rst_casig", casig, 0);
        chk("rst_data", rsp_data, 0);

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Both requesters hold WRMEM requests: grants must alternate.
        wait_idle();
        req_op = {2'b01, 2'b01};
        req_addr = {32'h0000_2000, 32'h0000_1000};
        req_valid = 2'b11;
        exp_id = (last_gid + 1) % NREQ;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (req_ready == '0 && n < 100);
            chk("alt_grant", req_ready, 1 << exp_id);
            @(posedge clk); #1;
            chk("alt_sel", eng_sel, 2'b01);
            chk("alt_rw", casig[47], 0);
            repeat (2) @(posedge clk);
            #1 eng_end = 4'b0010;
            @(posedge clk); #1;
            eng_end = '0;
            chk("alt_done", {rsp_done, rsp_err}, 2'b10);
            exp_id = (exp_id + 1) % NREQ;
        end
        req_valid = '0;

        // Reset during WAIT with an end and a beat pending.
        wait_idle();
        req_valid[1] = 1'b1;
        req_op[3:2] = 2'b10;
        req_addr[63:32] = 32'h0000_0040;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 eng_rd_valid = 2'b10;
        eng_rd_data = 32'h1234_0000;
        @(posedge clk); #1;
        chk("pre_rst_beat", {rsp_dvalid, rsp_data}, {1'b1, 16'h1234});
        rst = 1'b1;
        eng_end = 4'b0100;
        @(posedge clk); #1;
        rst = 1'b0;
        eng_end = '0;
        eng_rd_valid = '0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_outs", {req_ready, eng_start, eng_sel, rsp_dvalid, rsp_done, rsp_err, rsp_id}, 0);
        chk("mid_rst_casig", casig, 0);
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_done) n++;
        end
        chk("mid_rst_no_done", n, 0);
        req_valid = 2'b11;
        req_op = {2'b01, 2'b01};
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (req_ready == '0 && n < 100);
        chk("rst_rr_first", req_ready, 2'b01);
        req_valid = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
